// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter driving the select index of a 2-to-4 decoder,
// with a registered one-hot grant and an optional maximum hold time.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] CNT_SAT  = {HOLD_W{1'b1}};

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state, state_nx;
  logic [1:0]        last_idx, last_nx;
  logic [HOLD_W-1:0] cnt, cnt_nx;
  logic [3:0]        gnt_nx;
  logic [1:0]        idx_nx;
  logic              valid_nx, to_nx;
  logic              pick_valid;
  logic [1:0]        pick_idx;

  // First asserted request after last_idx, wrapping 3 -> 0; {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      c = last + 2'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  // Rotating-priority candidate for the next arbitration edge.
  always_comb begin
    {pick_valid, pick_idx} = rr_pick(req, last_idx);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    last_nx  = last_idx;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    idx_nx   = gnt_idx;
    valid_nx = gnt_valid;
    to_nx    = 1'b0;
    case (state)
      IDLE, GAP: begin
        gnt_nx   = 4'b0000;
        valid_nx = 1'b0;
        state_nx = IDLE;
        if (pick_valid) begin
          gnt_nx   = 4'b0001 << pick_idx;
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          last_nx  = pick_idx;
          cnt_nx   = HOLD_W'(1);
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          gnt_nx   = 4'b0000;
          valid_nx = 1'b0;
          state_nx = GAP;
        end else if ((MAX_HOLD != 0) && (cnt == HOLD_LIM)) begin
          gnt_nx   = 4'b0000;
          valid_nx = 1'b0;
          to_nx    = 1'b1;
          state_nx = GAP;
        end else if (cnt != CNT_SAT) begin
          cnt_nx = cnt + HOLD_W'(1);
        end
      end
      default: begin
        gnt_nx   = 4'b0000;
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs; last_idx resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_idx  <= 2'd3;
      cnt       <= '0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      last_idx  <= last_nx;
      cnt       <= cnt_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      timeout   <= to_nx;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter (MAX_HOLD=15 and MAX_HOLD=0 instances).
module tb_decoder_rr_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid, timeout;

  logic [3:0] req_b = 4'b0000;
  logic [3:0] gnt_b;
  logic [1:0] gnt_idx_b;
  logic       gnt_valid_b, timeout_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  decoder_rr_arbiter #(.MAX_HOLD(15), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid), .timeout(timeout)
  );

  decoder_rr_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(gnt_idx_b),
    .gnt_valid(gnt_valid_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got {gnt,idx,valid,to}=%b required %b at %0t", nm, act, expv, $time);
    end
  endtask

  // One-hot invariant on both instances every cycle.
  always @(negedge clk) begin
    check("inv_a", {gnt, 5'b0}, {(gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000), 5'b0});
    check("inv_b", {gnt_b, 5'b0}, {(gnt_valid_b ? (4'b0001 << gnt_idx_b) : 4'b0000), 5'b0});
  end

  // Drive req for one edge; expected outputs go to the scoreboard and are compared after the edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei,
                     input logic ev, input logic et, input string nm);
    exp_t e;
    req = r;
    e = '{gnt: eg, idx: ei, valid: ev, to: et};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(nm, {gnt, gnt_idx, gnt_valid, timeout}, {e.gnt, e.idx, e.valid, e.to});
  endtask

  task automatic do_reset();
    req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset_vals", {gnt, gnt_idx, gnt_valid, timeout}, 9'b0);
  endtask

  vec_t       tbl[4];
  int         m;
  logic [3:0] oh;

  initial begin
    tbl[0] = '{req: 4'b0001, gnt: 4'b0001, idx: 2'd0, valid: 1'b1, to: 1'b0};
    tbl[1] = '{req: 4'b0000, gnt: 4'b0000, idx: 2'd0, valid: 1'b0, to: 1'b0};
    tbl[2] = '{req: 4'b0000, gnt: 4'b0000, idx: 2'd0, valid: 1'b0, to: 1'b0};
    tbl[3] = '{req: 4'b0000, gnt: 4'b0000, idx: 2'd0, valid: 1'b0, to: 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_a", {gnt, gnt_idx, gnt_valid, timeout}, 9'b0);
    check("reset_b", {gnt_b, gnt_idx_b, gnt_valid_b, timeout_b}, 9'b0);

    // Single request, release, idle.
    for (int i = 0; i < 4; i++)
      cyc(tbl[i].req, tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].to, "basic");

    // Rotation 0,1,2,3,0 with 3-cycle grants and a one-cycle gap.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      m  = k % 4;
      oh = 4'b0001 << m;
      cyc(4'hF, oh, 2'(m), 1'b1, 1'b0, "rot_grant");
      repeat (2) cyc(4'hF, oh, 2'(m), 1'b1, 1'b0, "rot_hold");
      cyc(4'hF & ~oh, 4'h0, 2'(m), 1'b0, 1'b0, "rot_release");
    end
    cyc(4'h0, 4'h0, 2'd0, 1'b0, 1'b0, "rot_idle");

    // Timeout with no competitor: 15 cycles held, pulse, re-grant.
    do_reset();
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_grant");
    repeat (14) cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_keep");
    cyc(4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, "hold_timeout");
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_regrant");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "hold_release");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "hold_idle");

    // Timeout with a competitor: requester 3 wins the post-timeout arbitration.
    do_reset();
    cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "comp_grant1");
    repeat (14) cyc(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, "comp_keep1");
    cyc(4'b1010, 4'b0000, 2'd1, 1'b0, 1'b1, "comp_timeout");
    cyc(4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, "comp_grant3");
    repeat (2) cyc(4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, "comp_keep3");
    cyc(4'b0010, 4'b0000, 2'd3, 1'b0, 1'b0, "comp_release3");
    cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "comp_regrant1");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "comp_release1");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "comp_idle");

    // Asynchronous reset mid-grant, then priority restarts from last_idx=3.
    do_reset();
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "arst_pre2");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "arst_rel2");
    cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "arst_grant1");
    cyc(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "arst_keep1");
    #3 rst = 1'b1;
    #1 check("arst_async", {gnt, gnt_idx, gnt_valid, timeout}, 9'b0);
    req = 4'b1010;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, "arst_first");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "arst_release");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "arst_idle");

    // Timeout disabled: grant never drops.
    do_reset();
    req_b = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 check("nohold", {gnt_b, gnt_idx_b, gnt_valid_b, timeout_b}, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    req_b = 4'b0000;
    @(posedge clk);
    #1 check("nohold_release", {gnt_b, gnt_idx_b, gnt_valid_b, timeout_b}, {4'b0000, 2'd0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-way decoded resource (select lines sel[3:0]) between four requesters.
- Grants one requester at a time.
- Drives the 2-bit select index that feeds the team's 2-to-4 decoder, plus a registered one-hot grant.
- Enforces an optional maximum hold time so that no requester can starve the others.

Parameters:
- MAX_HOLD, 15, maximum consecutive cycles a grant may be held. 0 disables the timeout.
- HOLD_W, 4, width of the hold counter. Must satisfy MAX_HOLD <= 2^HOLD_W - 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] is held high while requester i wants or uses the resource.
- gnt  output  4  registered one-hot grant; all zero when no grant.
- gnt_idx  output  2  encoded index of the granted requester; feeds the decoder select.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - gnt=4'b0000, gnt_idx=2'd0, gnt_valid=0, timeout=0.
  - State=IDLE, hold counter=0.
  - last_idx=2'd3, so requester 0 has top priority after reset.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise select the first asserted req[i] scanning i = last_idx+1, last_idx+2, ... modulo 4 (wrap 3 -> 0).
  - On that edge: gnt[i]=1, gnt_idx=i, gnt_valid=1, last_idx=i, counter=1, go to GRANT.
  - Latency: gnt rises on the first rising edge that samples the req.
- GRANT:
  - gnt/gnt_idx are stable. Requests from other requesters are ignored (no preemption).
  - If req[gnt_idx]==0 on an edge: clear gnt, gnt_valid=0, go to GAP (normal release).
  - Else if MAX_HOLD!=0 and counter==MAX_HOLD:
    - Clear gnt, gnt_valid=0.
    - Pulse timeout=1 for exactly the next cycle.
    - Go to GAP (forced release).
  - Else counter increments by 1. Saturates; no wrap is possible given the parameter rule.
- GAP:
  - Exactly one cycle with gnt=0. Gives the decoder select a clean break-before-make.
  - Then arbitrate exactly as IDLE on the same edge. A new grant appears at the end of the GAP cycle.
- gnt_idx holds its last value while gnt_valid=0. Consumers must qualify it with gnt_valid.
- After a forced release, a requester that keeps req high is lowest priority (last_idx=it). It is re-granted only when no other request is pending.
- Simultaneous requests: the rotating-priority scan decides. Exactly one gnt bit is ever set.
- Invariant: gnt is one-hot or zero, and gnt == (gnt_valid << gnt_idx).
- rst asserted mid-grant: all outputs clear immediately, asynchronously. State returns to reset values, including last_idx=3.
- req changes during GAP or IDLE are sampled only at the arbitration edge. Glitches between edges have no effect.
- The counter counts cycles the grant has been held. With MAX_HOLD=15, a requester keeping req high holds gnt for exactly 15 cycles.

Test Plan:
- Reset, then req=4'b0001 -> gnt=4'b0001, gnt_idx=0, gnt_valid=1 after one edge. Drop req -> gnt=0 next edge, then idle.
- req=4'b1111 held with each requester dropping req after 3 cycles of grant, then re-raising -> grant order 0,1,2,3,0. Each grant lasts 3 cycles, separated by one gnt=0 cycle.
- MAX_HOLD=15, req=4'b0100 held continuously -> gnt=4'b0100 for 15 cycles. Then timeout=1 for one cycle with gnt=0, then re-granted to 2 (no competitor).
- Requester 1 holds past timeout while req[3] is high -> after the timeout gap, gnt=4'b1000 (index 3). Requester 1 is served only after 3 releases.
- rst pulsed asynchronously mid-grant (gnt=4'b0010) -> gnt=0, gnt_valid=0, timeout=0 immediately. Next req=4'b1010 -> index 1 granted first (last_idx reset to 3).
- MAX_HOLD=0, req[0] held for 100 cycles -> grant never drops and timeout stays 0. Assert the one-hot invariant on every cycle of every test.
